// File: rtl/setclr_pkg.sv
// Shared helpers for the set/clr drain: index width and round-robin pick.
package setclr_pkg;

    localparam int MAX_SRC = 256;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First set bit of pending at or above ptr, wrapping modulo n (n <= MAX_SRC).
    function automatic logic [7:0] rrSelect(input logic [MAX_SRC-1:0] pending,
                                            input logic [7:0]          ptr,
                                            input int                  n);
        logic [7:0] result;
        logic       found;
        int         j;
        result = '0;
        found  = 1'b0;
        for (int i = 0; i < MAX_SRC; i++) begin
            j = int'(ptr) + i;
            if (j >= n) j = j - n;
            if (!found && (i < n) && pending[8'(j)]) begin
                result = 8'(j);
                found  = 1'b1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/setclr_flag.sv
// Bank of sticky set-priority flags, frozen while the clock gate is low.
module setclr_flag #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_cg,
    input  logic [W-1:0] i_set,
    input  logic [W-1:0] i_clr,
    output logic [W-1:0] o_q
);

    always_ff @(posedge i_clk) begin
        if (i_rst)
            o_q <= '0;
        else if (i_cg)
            o_q <= i_set | (o_q & ~i_clr);
    end

endmodule

// File: rtl/setclr_drain.sv
// Drains sticky event flags round-robin into a valid/ready index stream.
// state | meaning
// EMPTY | output register holds nothing (o_valid = 0)
// FULL  | o_idx is presented and waits for i_ready (o_valid = 1)
module setclr_drain
    import setclr_pkg::*;
#(
    parameter int N_SRC = 8,
    localparam int IDX_W = idx_width(N_SRC)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cg,
    input  logic [N_SRC-1:0] i_set,
    output logic [N_SRC-1:0] o_pending,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_overrun,
    input  logic             i_overrunClr
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]       state_q;
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] ptr_next;
    logic [N_SRC-1:0] clr;
    logic             load;
    logic             lost;

    assign o_valid = (state_q == ST_FULL);
    assign o_idx   = idx_q;

    assign load     = (!o_valid || i_ready) && (|o_pending);
    assign sel      = IDX_W'(rrSelect(MAX_SRC'(o_pending), 8'(ptr_q), N_SRC));
    // N_SRC need not be a power of two, so the pointer wrap is explicit.
    assign ptr_next = (int'(sel) == N_SRC - 1) ? '0 : sel + IDX_W'(1);
    assign clr      = load ? (N_SRC'(1) << sel) : '0;
    assign lost     = |(i_set & o_pending & ~clr);

    setclr_flag #(.W(N_SRC)) u_pending (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_cg  (i_cg),
        .i_set (i_set),
        .i_clr (clr),
        .o_q   (o_pending)
    );

    setclr_flag #(.W(1)) u_overrun (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_cg  (i_cg),
        .i_set (lost),
        .i_clr (i_overrunClr),
        .o_q   (o_overrun)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_EMPTY;
            idx_q   <= '0;
            ptr_q   <= '0;
        end else if (i_cg) begin
            if (load) begin
                state_q <= ST_FULL;
                idx_q   <= sel;
                ptr_q   <= ptr_next;
            end else if (o_valid && i_ready) begin
                state_q <= ST_EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_setclr_drain.sv
// Directed-vector bench for setclr_drain with four sources.
module tb_setclr_drain;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_cg;
    logic [3:0] i_set;
    logic [3:0] o_pending;
    logic       o_valid;
    logic       i_ready;
    logic [1:0] o_idx;
    logic       o_overrun;
    logic       i_overrunClr;

    int vectors = 0;
    int errors  = 0;

    always #5 i_clk = ~i_clk;

    setclr_drain #(.N_SRC(4)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_cg         (i_cg),
        .i_set        (i_set),
        .o_pending    (o_pending),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_idx        (o_idx),
        .o_overrun    (o_overrun),
        .i_overrunClr (i_overrunClr)
    );

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst = 1'b1; i_cg = 1'b1; i_set = '0; i_ready = 1'b1; i_overrunClr = 1'b0;
        tick();
        tick();
        i_rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({o_pending, o_valid, o_idx, o_overrun} !== 8'h00) begin
            errors++;
            $display("FAIL reset_state got pend=%b v=%b idx=%0d ovr=%b exp all zero",
                     o_pending, o_valid, o_idx, o_overrun);
        end
    endtask

    task automatic test_single();
        do_reset();
        i_set = 4'b0100;
        tick();
        i_set = '0;
        vectors++;
        if (o_pending !== 4'b0100 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_t1 got pend=%b v=%b exp pend=0100 v=0", o_pending, o_valid);
        end
        tick();
        vectors++;
        if (o_valid !== 1'b1 || o_idx !== 2'd2 || o_pending !== 4'b0000) begin
            errors++;
            $display("FAIL single_t2 got v=%b idx=%0d pend=%b exp v=1 idx=2 pend=0000",
                     o_valid, o_idx, o_pending);
        end
        tick();
        vectors++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_one_beat got v=%b exp v=0", o_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_idx [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
        logic [3:0] exp_pnd [4] = '{4'b1110, 4'b1100, 4'b1000, 4'b0000};
        do_reset();
        i_set = 4'b1111;
        tick();
        i_set = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            vectors++;
            if (o_valid !== 1'b1 || o_idx !== exp_idx[k] || o_pending !== exp_pnd[k]) begin
                errors++;
                $display("FAIL rr_beat%0d got v=%b idx=%0d pend=%b exp v=1 idx=%0d pend=%b",
                         k, o_valid, o_idx, o_pending, exp_idx[k], exp_pnd[k]);
            end
        end
        tick();
        vectors++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL rr_drained got v=%b exp v=0", o_valid);
        end
    endtask

    task automatic test_back_pressure();
        do_reset();
        i_ready = 1'b0;
        i_set   = 4'b0010;
        tick();
        i_set = '0;
        tick();
        i_set = 4'b1000;
        for (int k = 0; k < 5; k++) begin
            tick();
            i_set = '0;
            vectors++;
            if (o_valid !== 1'b1 || o_idx !== 2'd1) begin
                errors++;
                $display("FAIL bp_stall%0d got v=%b idx=%0d exp v=1 idx=1", k, o_valid, o_idx);
            end
        end
        i_ready = 1'b1;
        tick();
        vectors++;
        if (o_valid !== 1'b1 || o_idx !== 2'd3 || o_overrun !== 1'b0) begin
            errors++;
            $display("FAIL bp_release got v=%b idx=%0d ovr=%b exp v=1 idx=3 ovr=0",
                     o_valid, o_idx, o_overrun);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        i_ready = 1'b0;
        i_set   = 4'b0001;
        tick();
        i_set = '0;
        tick();
        i_set = 4'b0001;
        tick();
        i_set = '0;
        vectors++;
        if (o_overrun !== 1'b0 || o_pending !== 4'b0001) begin
            errors++;
            $display("FAIL ovr_first got ovr=%b pend=%b exp ovr=0 pend=0001", o_overrun, o_pending);
        end
        tick();
        i_set = 4'b0001;
        tick();
        i_set = '0;
        vectors++;
        if (o_overrun !== 1'b1 || o_idx !== 2'd0) begin
            errors++;
            $display("FAIL ovr_set got ovr=%b idx=%0d exp ovr=1 idx=0", o_overrun, o_idx);
        end
        i_overrunClr = 1'b1;
        tick();
        i_overrunClr = 1'b0;
        vectors++;
        if (o_overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_clear got ovr=%b exp ovr=0", o_overrun);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        i_set = 4'b0100;
        tick();
        tick();
        i_set = '0;
        vectors++;
        if (o_valid !== 1'b1 || o_idx !== 2'd2 || o_pending !== 4'b0100 || o_overrun !== 1'b0) begin
            errors++;
            $display("FAIL simul_load got v=%b idx=%0d pend=%b ovr=%b exp v=1 idx=2 pend=0100 ovr=0",
                     o_valid, o_idx, o_pending, o_overrun);
        end
        tick();
        vectors++;
        if (o_valid !== 1'b1 || o_idx !== 2'd2 || o_pending !== 4'b0000) begin
            errors++;
            $display("FAIL simul_second got v=%b idx=%0d pend=%b exp v=1 idx=2 pend=0000",
                     o_valid, o_idx, o_pending);
        end
        tick();
        vectors++;
        if (o_valid !== 1'b0 || o_overrun !== 1'b0) begin
            errors++;
            $display("FAIL simul_end got v=%b ovr=%b exp v=0 ovr=0", o_valid, o_overrun);
        end
    endtask

    task automatic test_reset_gating();
        do_reset();
        i_set = 4'b1011;
        tick();
        i_set = '0;
        tick();
        vectors++;
        if (o_pending !== 4'b1010 || o_valid !== 1'b1 || o_idx !== 2'd0) begin
            errors++;
            $display("FAIL midrst_setup got pend=%b v=%b idx=%0d exp pend=1010 v=1 idx=0",
                     o_pending, o_valid, o_idx);
        end
        i_rst = 1'b1;
        i_cg  = 1'b0;
        tick();
        i_rst = 1'b0;
        i_cg  = 1'b1;
        vectors++;
        if ({o_pending, o_valid, o_idx, o_overrun} !== 8'h00) begin
            errors++;
            $display("FAIL midrst_clear got pend=%b v=%b idx=%0d ovr=%b exp all zero",
                     o_pending, o_valid, o_idx, o_overrun);
        end
        i_ready = 1'b0;
        i_set   = 4'b0001;
        tick();
        i_set = '0;
        tick();
        i_set = 4'b0100;
        tick();
        i_cg         = 1'b0;
        i_set        = 4'b0111;
        i_ready      = 1'b1;
        i_overrunClr = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        vectors++;
        if (o_pending !== 4'b0100 || o_valid !== 1'b1 || o_idx !== 2'd0 || o_overrun !== 1'b0) begin
            errors++;
            $display("FAIL gate_hold got pend=%b v=%b idx=%0d ovr=%b exp pend=0100 v=1 idx=0 ovr=0",
                     o_pending, o_valid, o_idx, o_overrun);
        end
        i_cg         = 1'b1;
        i_set        = '0;
        i_overrunClr = 1'b0;
        tick();
        vectors++;
        if (o_valid !== 1'b1 || o_idx !== 2'd2 || o_pending !== 4'b0000) begin
            errors++;
            $display("FAIL gate_resume got v=%b idx=%0d pend=%b exp v=1 idx=2 pend=0000",
                     o_valid, o_idx, o_pending);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_back_pressure();
        test_overrun();
        test_simultaneous();
        test_reset_gating();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/setclr_drain.md
# setclr_drain

Consumer end of a bank of set/clr sticky flags. N event sources pulse `i_set`; each flag holds the event pending until the drain picks it, clears it, and presents its index on a valid/ready stream. The drain serialises events from interrupt-style or status-style sources into an index stream for a downstream sequencer or CSR log. Round-robin selection guarantees no source is starved.

## Interface
- `N_SRC`, default 8: number of sources; legal range 2..256.
- `IDX_W`, default `$clog2(N_SRC)`: index width; localparam, not overridable.
- `i_clk`  input  1: clock.
- `i_rst`  input  1: synchronous reset, active-high.
- `i_cg`  input  1: clock-gate enable; when low, all state holds and inputs are ignored.
- `i_set`  input  N_SRC: per-source event pulse, one bit per source.
- `o_pending`  output  N_SRC: current sticky flags.
- `o_valid`  output  1: index available.
- `i_ready`  input  1: downstream accepts the index.
- `o_idx`  output  IDX_W: source index of the presented event.
- `o_overrun`  output  1: sticky flag; an event was lost.
- `i_overrunClr`  input  1: clears `o_overrun`.

## Operation
- **Pending flags.** Per bit k: `pending_d[k] = set[k] || (pending_q[k] && !clr[k])`. Set has priority over clr. `clr[k]` is high only on the cycle index k is loaded into the output register.
- **Overrun.** `lost = |(i_set & pending_q & ~clr)`. `o_overrun` uses set priority: `d = lost || (q && !i_overrunClr)`.
- **Load condition.** `load = (!o_valid || i_ready) && |pending_q`.
- **Round-robin selection.** The selected index is the first set bit of `pending_q` at or above `ptr_q`, wrapping modulo N_SRC.
- **On load:**
  - `o_idx` takes the selected index.
  - `o_valid` is set.
  - `clr[sel]` pulses.
  - `ptr_d = (sel + 1) mod N_SRC`. The wrap is explicit; N_SRC need not be a power of 2.
- **No load.** If `o_valid && i_ready && !(|pending_q)`, `o_valid` clears. Otherwise `o_valid` and `o_idx` hold.
- **Stability.** While `o_valid && !i_ready`, `o_idx` must not change.
- **Output state machine.** Two states, encoded by `o_valid`:
  - EMPTY → FULL on load.
  - FULL → FULL on handshake with load, or on stall.
  - FULL → EMPTY on handshake with no pending flags.
- **Same-source set during clear.** `i_set[k]` on the cycle k is cleared keeps k pending. This is a new event, not an overrun.

## Timing
- **Reset values.** `pending`=0, `o_valid`=0, `o_idx`=0, `ptr`=0, `o_overrun`=0.
- **Latency.** `i_set` in cycle t gives `pending` at t+1 and `o_valid` with `o_idx` at t+2, provided the output register is empty or draining.
- **Throughput.** One index per cycle while `i_ready` stays high and flags are pending.
- **Visibility of clear.** `o_pending[k]` drops in the cycle after the edge that loads k.
- **Mid-operation reset.** `i_rst` overrides everything, including `i_cg`. All pending events and the held index are discarded.
- **Overrun.** `o_overrun` rises one cycle after the lost event. `i_overrunClr` together with a new loss leaves it high.

## Structure
- The package `setclr_pkg` holds:
  - function `rrSelect(pending, ptr)`, returning the index;
  - the localparam computation for IDX_W.
- A `setclr_flag` sub-module is natural: a parameterised-width bank of set-priority flops with a `i_cg` gate. Instantiate it once for `pending` and once, at width 1, for `overrun`.
- Everything else stays in the top-level module.

## Test plan
All scenarios use N_SRC=4.
- **Single event.** After reset, `i_set`=4'b0100 for one cycle with `i_ready`=1 → `o_valid`=1 and `o_idx`=2 two cycles later. `o_pending` returns to 0. Exactly one valid beat.
- **Round-robin order.** `i_set`=4'b1111 in one cycle, ready always high → indices 0,1,2,3 on consecutive cycles, then `o_valid`=0.
- **Back-pressure.** With index 1 presented, `i_ready`=0 for 5 cycles while `i_set`=4'b1000 → `o_idx` stays 1. Index 3 follows on the cycle after `i_ready` rises. No overrun.
- **Overrun.** `i_set[0]` pulses twice, 2 cycles apart, with `i_ready`=0 and the output holding index 0 from an earlier event → `o_overrun`=1. `i_overrunClr` pulse → 0 one cycle later.
- **Simultaneous set/clr.** `i_set[2]` on the cycle index 2 is loaded → `pending[2]` stays 1, a second index-2 beat follows, and `o_overrun` stays 0.
- **Reset and gating.** `i_rst` asserted mid-burst with `pending`=4'b1010 → all outputs 0 next cycle. Separately, `i_cg`=0 during `i_set` activity → no state change.
